// File: rtl/operand_register_file.sv
// operand_register_file: four general registers (R1-R4) and four optional
// scratch registers (S1-S4) that feed the ALU A and B operand inputs.
// One FunSel operation is applied per clock to every register whose enable
// is set; the two read ports are purely combinational.
// Optional feature macro: SCRATCH_REGS_EN (defined = S1-S4 implemented;
// undefined = ScrSel ignored and scratch read selects return 0).
module operand_register_file #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);

    // Byte and half-word lane masks; the partial loads need WIDTH >= 16.
    localparam logic [WIDTH-1:0] LOW8_MASK  = WIDTH'(8'hFF);
    localparam logic [WIDTH-1:0] LOW16_MASK = WIDTH'(16'hFFFF);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    // Next value of one register for the current FunSel, from its own value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [WIDTH-1:0] cur,
        input logic [2:0]       fun,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] result;
        result = cur;
        case (fun)
            3'b000: result = cur - ONE;
            3'b001: result = cur + ONE;
            3'b010: result = din;
            3'b011: result = '0;
            3'b100: result = din & LOW8_MASK;
            3'b101: result = (cur & ~LOW8_MASK) | (din & LOW8_MASK);
            3'b110: result = (cur & ~LOW16_MASK) | (din & LOW16_MASK);
            3'b111: result = {{(WIDTH-8){din[7]}}, din[7:0]};
            default: result = cur;
        endcase
        return result;
    endfunction

    logic [WIDTH-1:0] gen_value [4];
    logic [WIDTH-1:0] scr_value [4];

    // General registers R1-R4, one register per enable bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gen_reg
            logic [WIDTH-1:0] value_reg;

            // Reset clears; otherwise apply FunSel when this register is enabled.
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    value_reg <= '0;
                end else if (RegSel[gi]) begin
                    value_reg <= apply_op(value_reg, FunSel, I);
                end
            end

            assign gen_value[gi] = value_reg;
        end
    endgenerate

`ifdef SCRATCH_REGS_EN
    // Scratch registers S1-S4, identical behaviour under ScrSel.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scr_reg
            logic [WIDTH-1:0] value_reg;

            // Reset clears; otherwise apply FunSel when this scratch is enabled.
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    value_reg <= '0;
                end else if (ScrSel[gi]) begin
                    value_reg <= apply_op(value_reg, FunSel, I);
                end
            end

            assign scr_value[gi] = value_reg;
        end
    endgenerate
`else
    // Scratch bank absent: its read selects see zero and ScrSel is discarded.
    logic unused_scr_sel;
    assign unused_scr_sel = ^ScrSel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scr_zero
            assign scr_value[gi] = '0;
        end
    endgenerate
`endif

    // Read ports: bit 2 of the select chooses the scratch bank. No write bypass.
    always_comb begin
        OutA = '0;
        OutB = '0;
        if (OutASel[2]) begin
            OutA = scr_value[OutASel[1:0]];
        end else begin
            OutA = gen_value[OutASel[1:0]];
        end
        if (OutBSel[2]) begin
            OutB = scr_value[OutBSel[1:0]];
        end else begin
            OutB = gen_value[OutBSel[1:0]];
        end
    end

endmodule

// File: tb/tb_operand_register_file.sv
// Directed testbench for operand_register_file; expected values are hand-computed.
// Scratch-register expectations follow whether SCRATCH_REGS_EN is defined.
module tb_operand_register_file;

    logic        Clock;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [31:0] OutA;
    logic [31:0] OutB;

    int checks   = 0;
    int failures = 0;

    operand_register_file #(.WIDTH(32)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (I),
        .FunSel (FunSel),
        .RegSel (RegSel),
        .ScrSel (ScrSel),
        .OutASel(OutASel),
        .OutBSel(OutBSel),
        .OutA   (OutA),
        .OutB   (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef SCRATCH_REGS_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Present a selection on both ports and compare each port.
    task automatic read2(input string tag, input logic [2:0] sa, input logic [31:0] ea,
                         input logic [2:0] sb, input logic [31:0] eb);
        OutASel = sa;
        OutBSel = sb;
        #1;
        check({tag, "_A"}, OutA, ea);
        check({tag, "_B"}, OutB, eb);
    endtask

    task automatic op(input logic [2:0] fs, input logic [31:0] din,
                      input logic [3:0] rs, input logic [3:0] ss);
        FunSel = fs;
        I      = din;
        RegSel = rs;
        ScrSel = ss;
        step();
        RegSel = 4'b0000;
        ScrSel = 4'b0000;
    endtask

    initial begin
        Reset = 1'b1; I = '0; FunSel = 3'b000; RegSel = 4'b0000; ScrSel = 4'b0000;
        OutASel = 3'b000; OutBSel = 3'b111;
        step();
        Reset = 1'b0;
        read2("reset", 3'b000, 32'h0, 3'b111, 32'h0);

        // Full load into R1 and R3 only
        op(3'b010, 32'h12345678, 4'b0101, 4'b0000);
        read2("ld_r1r2", 3'b000, 32'h12345678, 3'b001, 32'h0);
        read2("ld_r3r4", 3'b010, 32'h12345678, 3'b011, 32'h0);

        // Low-byte and low-half loads hold upper bits
        op(3'b101, 32'h000000AB, 4'b0001, 4'b0000);
        read2("lowbyte", 3'b000, 32'h123456AB, 3'b010, 32'h12345678);
        op(3'b110, 32'hCAFEBEEF, 4'b0100, 4'b0000);
        read2("lowhalf", 3'b010, 32'h1234BEEF, 3'b000, 32'h123456AB);

        // Increment wraps to 0, decrement wraps to all-ones
        op(3'b010, 32'hFFFFFFFF, 4'b0010, 4'b0000);
        op(3'b001, 32'h0, 4'b0010, 4'b0000);
        read2("inc_wrap", 3'b001, 32'h0, 3'b001, 32'h0);
        FunSel = 3'b000; RegSel = 4'b0010;
        step(); step();
        RegSel = 4'b0000;
        read2("dec_x2", 3'b001, 32'hFFFFFFFE, 3'b000, 32'h123456AB);

        // Scratch S4 sign-extend then zero-extend of the same byte
        op(3'b111, 32'h00000080, 4'b0000, 4'b1000);
        read2("scr_sext", 3'b111, SCR ? 32'hFFFFFF80 : 32'h0, 3'b110, 32'h0);
        op(3'b100, 32'h00000080, 4'b0000, 4'b1000);
        read2("scr_zext", 3'b111, SCR ? 32'h00000080 : 32'h0, 3'b011, 32'h0);

        // Sign-extend into R4 ignores the upper bits of I
        op(3'b111, 32'h12345685, 4'b1000, 4'b0000);
        read2("r4_sext", 3'b011, 32'hFFFFFF85, 3'b010, 32'h1234BEEF);

        // Read-during-write: old value until the edge
        op(3'b010, 32'h00000005, 4'b0001, 4'b0000);
        FunSel = 3'b011; RegSel = 4'b0001;
        read2("clr_before", 3'b000, 32'h5, 3'b000, 32'h5);
        step();
        RegSel = 4'b0000;
        read2("clr_after", 3'b000, 32'h0, 3'b000, 32'h0);

        // Reset overrides a concurrent increment on every register
        op(3'b010, 32'h0000BEEF, 4'b0001, 4'b0000);
        FunSel = 3'b001; RegSel = 4'b1111; ScrSel = 4'b1111; Reset = 1'b1;
        step();
        Reset = 1'b0; RegSel = 4'b0000; ScrSel = 4'b0000;
        read2("rst_r1r2", 3'b000, 32'h0, 3'b001, 32'h0);
        read2("rst_r3r4", 3'b010, 32'h0, 3'b011, 32'h0);
        read2("rst_s1s2", 3'b100, 32'h0, 3'b101, 32'h0);
        read2("rst_s3s4", 3'b110, 32'h0, 3'b111, 32'h0);

        // Held increment: three edges give +3, reset mid-loop restarts at 0
        FunSel = 3'b001; RegSel = 4'b0001;
        step(); step(); step();
        read2("inc_x3", 3'b000, 32'h3, 3'b001, 32'h0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        read2("inc_rst", 3'b000, 32'h0, 3'b000, 32'h0);
        step();
        RegSel = 4'b0000;
        read2("inc_resume", 3'b000, 32'h1, 3'b001, 32'h0);

        // Scratch write visible only when scratch bank is built
        op(3'b010, 32'hDEADBEEF, 4'b0000, 4'b0100);
        read2("scr_s3", 3'b110, SCR ? 32'hDEADBEEF : 32'h0, 3'b000, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
